// File: rtl/fifo_uart_tx.sv
// Purpose: pops words from a register FIFO and serializes them as start/data(LSB first)/parity/stop frames.
// Latency: tx falls on the edge that pops the word; a frame occupies (1+WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: fetches only in IDLE with en=1 and empty=0; en and empty never disturb a frame already in flight.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             shift_out,
  output logic             tx,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic             par_q, par_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             bit_end;

  // Pop strobe: only from IDLE, and never while reset is asserted.
  assign shift_out = (state_q == S_IDLE) & en & ~empty & res_n;
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);
  assign bit_end   = (cyc_q == CYC_LAST);

  // Next-state: bit timing, frame sequencing and the registered line value.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    par_d   = par_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cyc_d   = (state_q == S_IDLE || bit_end) ? '0 : cyc_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (shift_out) begin
          shreg_d = rdata;
          par_d   = (PARITY == 2) ? ~^rdata : ^rdata;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          tx_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; an in-flight word is dropped.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      par_q   <= 1'b0;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      par_q   <= par_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: even-parity and odd-parity instances share one FIFO model.
// Every cycle is compared against a frame-countdown reference model; tables and sequences add targeted checks.
// The FIFO model pops on the DUT strobe; inputs change 1 time unit after the rising edge.
module tb_fifo_uart_tx;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = 44;
  localparam int SPACING   = 45;

  logic       clk   = 1'b0;
  logic       res_n = 1'b0;
  logic       en    = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       so_e, tx_e, busy_e, so_o, tx_o, busy_o;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .res_n(res_n), .en(en), .empty(empty), .rdata(rdata),
    .shift_out(so_e), .tx(tx_e), .busy(busy_e));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .res_n(res_n), .en(en), .empty(empty), .rdata(rdata),
    .shift_out(so_o), .tx(tx_o), .busy(busy_o));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;
  int         pop_while_empty = 0;
  logic [7:0] fq[$];
  logic       s_so, s_tx, s_tx2, s_busy;
  int         m_left = 0;
  logic [10:0] m_fr_e = '1;
  logic [10:0] m_fr_o = '1;

  typedef struct {
    logic [7:0] word;
    logic       par_even;
    logic       par_odd;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic drive_fifo();
    empty = (fq.size() == 0);
    rdata = empty ? 8'($urandom) : fq[0];
  endtask

  // One clock: sample at the falling edge, compare with the model, then advance model and FIFO.
  task automatic step();
    logic e_so, e_busy, e_tx, e_tx2;
    int   idx;
    @(negedge clk);
    s_so   = so_e;
    s_tx   = tx_e;
    s_tx2  = tx_o;
    s_busy = busy_e;
    if (s_so && empty) pop_while_empty++;
    e_so   = res_n && en && !empty && (m_left == 0);
    e_busy = (m_left > 0);
    idx    = (m_left > 0) ? (FRAME_CYC - m_left) / CPB : 0;
    e_tx   = (m_left > 0) ? m_fr_e[idx] : 1'b1;
    e_tx2  = (m_left > 0) ? m_fr_o[idx] : 1'b1;
    chk("shift_out_even", 32'(s_so), 32'(e_so));
    chk("shift_out_odd", 32'(so_o), 32'(e_so));
    chk("tx_even", 32'(s_tx), 32'(e_tx));
    chk("tx_odd", 32'(s_tx2), 32'(e_tx2));
    chk("busy_even", 32'(s_busy), 32'(e_busy));
    chk("busy_odd", 32'(busy_o), 32'(e_busy));
    @(posedge clk);
    #1;
    cyc_n++;
    if (!res_n) begin
      m_left = 0;
    end else if (e_so) begin
      m_left = FRAME_CYC;
      m_fr_e = {1'b1, ^fq[0], fq[0], 1'b0};
      m_fr_o = {1'b1, ~^fq[0], fq[0], 1'b0};
    end else if (m_left > 0) begin
      m_left--;
    end
    if (s_so && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic wait_pop(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (s_so) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Collects the frame following a pop and returns the data bits sampled mid-bit.
  task automatic capture_word(output logic [7:0] w);
    logic txs[FRAME_CYC];
    for (int c = 0; c < FRAME_CYC; c++) begin
      step();
      txs[c] = s_tx;
    end
    for (int k = 0; k < 8; k++) w[k] = txs[CPB * (1 + k) + CPB / 2];
  endtask

  initial begin
    logic [7:0] words[5];
    logic [7:0] got;
    int         pops[$];
    logic       txlog[$];
    int         cnt;

    vt[0] = '{8'hA5, 1'b0, 1'b1};
    vt[1] = '{8'h07, 1'b1, 1'b0};
    vt[2] = '{8'h00, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 1'b0, 1'b1};
    vt[4] = '{8'h80, 1'b1, 1'b0};
    vt[5] = '{8'h3C, 1'b0, 1'b1};

    // Reset held with a non-empty FIFO: line stays quiet, first pop on release.
    fq.push_back(8'h3C);
    drive_fifo();
    en  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_so !== 1'b0) cnt++;
    end
    chk("reset_quiet", 32'(cnt), 32'd0);
    res_n = 1'b1;
    step();
    chk("first_pop_after_reset", 32'(s_so), 32'd1);
    capture_word(got);
    chk("reset_word_decoded", 32'(got), 32'h3C);
    for (int i = 0; i < 3; i++) step();

    // Table: single words, full frame shape on both parity flavours plus busy length.
    for (int v = 0; v < 6; v++) begin
      logic [10:0] fe, fo;
      logic        te[FRAME_CYC + 4];
      logic        to[FRAME_CYC + 4];
      fq.push_back(vt[v].word);
      drive_fifo();
      wait_pop(10, "table_pop");
      cnt = 0;
      for (int c = 0; c < FRAME_CYC + 4; c++) begin
        step();
        te[c] = s_tx;
        to[c] = s_tx2;
        if (s_busy) cnt++;
      end
      chk("table_busy_cycles", 32'(cnt), 32'(FRAME_CYC));
      fe = {1'b1, vt[v].par_even, vt[v].word, 1'b0};
      fo = {1'b1, vt[v].par_odd, vt[v].word, 1'b0};
      for (int b = 0; b < 11; b++) begin
        chk("table_bit_even", 32'({te[b*4], te[b*4+1], te[b*4+2], te[b*4+3]}), 32'({4{fe[b]}}));
        chk("table_bit_odd", 32'({to[b*4], to[b*4+1], to[b*4+2], to[b*4+3]}), 32'({4{fo[b]}}));
      end
    end

    // Five random words back to back: fixed pop spacing and order preserved.
    for (int i = 0; i < 5; i++) begin
      words[i] = 8'($urandom);
      fq.push_back(words[i]);
    end
    drive_fifo();
    for (int c = 0; c < 5 * SPACING + 60; c++) begin
      step();
      txlog.push_back(s_tx);
      if (s_so) pops.push_back(c);
    end
    chk("b2b_pop_count", 32'(pops.size()), 32'd5);
    for (int i = 1; i < pops.size(); i++)
      chk("b2b_spacing", 32'(pops[i] - pops[i-1]), 32'(SPACING));
    for (int i = 0; i < pops.size() && i < 5; i++) begin
      for (int k = 0; k < 8; k++) got[k] = txlog[pops[i] + 1 + CPB * (1 + k) + CPB / 2];
      chk("b2b_decoded", 32'(got), 32'(words[i]));
    end

    // en dropped during word 2 of 3: word 2 finishes, no fetch until en returns.
    for (int i = 0; i < 3; i++) fq.push_back(8'(8'h11 * (i + 1)));
    drive_fifo();
    wait_pop(10, "en_pop1");
    wait_pop(60, "en_pop2");
    for (int i = 0; i < 10; i++) step();
    en  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (s_so) cnt++;
    end
    chk("no_pop_while_en_low", 32'(cnt), 32'd0);
    chk("idle_while_en_low", 32'(s_busy), 32'd0);
    en = 1'b1;
    step();
    chk("pop_on_en_return", 32'(s_so), 32'd1);
    capture_word(got);
    chk("en_word3_decoded", 32'(got), 32'h33);
    step();

    // Reset during the data bits of 0xFF: frame dropped, next word sent cleanly.
    fq.push_back(8'hFF);
    fq.push_back(8'h5A);
    drive_fifo();
    wait_pop(10, "rst_pop_ff");
    for (int i = 0; i < 12; i++) step();
    res_n = 1'b0;
    step();
    chk("no_pop_in_reset", 32'(s_so), 32'd0);
    res_n = 1'b1;
    step();
    chk("tx_high_after_reset", 32'(s_tx), 32'd1);
    chk("pop_after_reset", 32'(s_so), 32'd1);
    capture_word(got);
    chk("post_reset_word", 32'(got), 32'h5A);
    chk("ff_not_refetched", 32'(fq.size()), 32'd0);

    // Random traffic, en toggling and rare resets against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 5) fq.push_back(8'($urandom));
      en    = ($urandom_range(0, 9) != 0);
      res_n = ($urandom_range(0, 399) != 0);
      drive_fifo();
      step();
    end
    en    = 1'b1;
    res_n = 1'b1;
    for (int i = 0; i < 6 * SPACING && (fq.size() > 0 || s_busy); i++) step();
    chk("drained", 32'(fq.size()), 32'd0);
    chk("pop_while_empty", 32'(pop_while_empty), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the register-based FIFO. Drains FIFO entries via the FIFO's empty/shift_out/rdata interface and serializes each word onto a UART-style line.
- Frame format: start bit, data LSB first, optional parity, stop bit(s).
- Sits between the FIFO read port and the chip pin driver. Frames are sent back-to-back while the FIFO holds data and enable is high.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; minimum 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- res_n  input  1  reset; synchronous, active-low.
- en  input  1  fetch enable; gates only the start of new frames.
- empty  input  1  FIFO empty flag.
- rdata  input  WIDTH  FIFO head word; valid whenever empty=0.
- shift_out  output  1  FIFO pop strobe.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while a frame is in flight (any state other than IDLE).

Behaviour:
- Reset (res_n=0 at a rising edge): state=IDLE, tx=1, busy=0, bit and cycle counters cleared, shift register cleared. shift_out=0 while res_n=0.
- shift_out is combinational: shift_out = (state==IDLE) & en & ~empty & res_n. It is high at most one cycle per frame. It is never asserted while empty=1.
- Pop edge (shift_out=1): shift register <= rdata; parity <= ^rdata (even) or ~^rdata (odd); tx <= 0; state <= START.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- A cycle counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. Each serial bit is held on tx for exactly CLKS_PER_BIT cycles.
- START: tx=0.
- DATA: tx = shift_reg[0]; shift right once per bit; WIDTH bits total, LSB first.
- PARITY: present only if PARITY!=0; one bit time.
- STOP: tx=1 for STOP_BITS bit times.
- At the last cycle of the last stop bit, state <= IDLE. In IDLE the next pop may occur in that same cycle.
- Pop-to-pop spacing for back-to-back frames: 1 + (1 + WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = (PARITY!=0).
- Pop cycle counts as busy=0. busy goes high the cycle after the pop and stays high through the last stop-bit cycle.
- en=0 during a frame: the current frame completes unchanged; no new pop occurs until en=1.
- empty rising mid-frame: no effect on the current frame.
- rdata changing mid-frame: ignored, because the word is latched at the pop edge.
- Reset mid-frame: at the next edge, tx=1 and state=IDLE. The in-flight word is discarded and not re-fetched. No pop occurs in the reset cycle.
- Invalid parameters (CLKS_PER_BIT<2, PARITY>2, STOP_BITS not 1 or 2): flagged by an elaboration-time $error.

Test Plan:
- Reset with FIFO non-empty, res_n=0 for 10 cycles -> tx=1, busy=0, shift_out=0 throughout; first pop occurs on the first edge with res_n=1 and en=1.
- WIDTH=8, CPB=4, PARITY=1, STOP=1, one word 0xA5 -> tx after the pop:
  - 0 for 4 cycles;
  - then 1,0,1,0,0,1,0,1 at 4 cycles each;
  - parity 0 for 4 cycles;
  - stop 1 for 4 cycles;
  - busy high for exactly 44 cycles.
- Same configuration, PARITY=2, word 0x07 -> parity bit 0 (three ones, odd parity already satisfied); PARITY=1 with 0x07 -> parity bit 1.
- Fill the FIFO (DEPTH=5) with random words, en=1 -> 5 pops exactly 45 cycles apart (PARITY=1, STOP=1); decoded bytes match write order; shift_out=0 once empty=1.
- en dropped mid-frame of word 2 of 3 -> word 2 completes; no pop while en=0; word 3 is popped on the first IDLE cycle after en returns to 1.
- res_n pulsed low during the DATA bits of 0xFF -> tx=1 at the next edge; the word is not retransmitted; the next FIFO word is sent correctly after reset is released.
